// File: rtl/branch_recovery_ctrl.sv
// branch_recovery_ctrl: sequences fetch redirect and pipeline flush after a branch
// misprediction, and queues predictor updates in a 2-entry FIFO.
module branch_recovery_ctrl #(
    parameter int size         = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ex_valid_i,
    input  logic            misprediction_i,
    input  logic [size-1:0] correct_pc_i,
    input  logic            update_valid_i,
    input  logic [size-1:0] update_pc_i,
    input  logic            update_taken_i,
    input  logic            redirect_ready_i,
    input  logic            upd_ready_i,
    output logic            redirect_valid_o,
    output logic [size-1:0] redirect_pc_o,
    output logic            flush_if_o,
    output logic            flush_id_o,
    output logic            stall_o,
    output logic            upd_valid_o,
    output logic [size-1:0] upd_pc_o,
    output logic            upd_taken_o,
    output logic            upd_overflow_o
);
    typedef enum logic [1:0] {IDLE, REDIRECT, DRAIN} state_t;
    state_t state, state_next;
    logic [2:0] cnt;
    logic [size:0] mem [2];
    logic wr_ptr, rd_ptr;
    logic [1:0] count;
    logic mispredict, push, pop, full, accept;

    assign mispredict = state == IDLE && ex_valid_i && misprediction_i;
    assign push       = state == IDLE && ex_valid_i && update_valid_i;
    assign pop        = upd_valid_o && upd_ready_i;
    assign full       = count == 2'd2;
    assign accept     = push && (!full || pop);

    always_ff @(posedge clk)
        if (!reset) state <= IDLE;
        else        state <= state_next;

    always_comb begin
        state_next = mispredict                         ? REDIRECT :
                     (state == REDIRECT && redirect_ready_i) ? DRAIN :
                     (state == DRAIN && cnt == 3'd1)         ? IDLE  : state;
    end

    assign redirect_valid_o = state == REDIRECT;
    assign stall_o          = state == REDIRECT;
    assign flush_if_o       = state != IDLE;
    assign flush_id_o       = state != IDLE;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt           <= '0;
            redirect_pc_o <= '0;
        end else begin
            if (mispredict) redirect_pc_o <= correct_pc_i;
            if (state == REDIRECT && redirect_ready_i) cnt <= 3'(DRAIN_CYCLES);
            else if (state == DRAIN)                   cnt <= cnt - 3'd1;
        end
    end

    // Entries are {pc, taken}; a full FIFO still accepts when the head leaves the same cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem[0]         <= '0;
            mem[1]         <= '0;
            wr_ptr         <= 1'b0;
            rd_ptr         <= 1'b0;
            count          <= '0;
            upd_overflow_o <= 1'b0;
        end else begin
            if (accept) begin
                mem[wr_ptr] <= {update_pc_i, update_taken_i};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + 2'(accept) - 2'(pop);
            if (push && full && !pop) upd_overflow_o <= 1'b1;
        end
    end

    assign upd_valid_o             = count != 2'd0;
    assign {upd_pc_o, upd_taken_o} = mem[rd_ptr];
endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// tb_branch_recovery_ctrl: directed scenarios for redirect/flush sequencing and the update FIFO.
module tb_branch_recovery_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ex_valid_i = 1'b0, misprediction_i = 1'b0, update_valid_i = 1'b0, update_taken_i = 1'b0;
    logic        redirect_ready_i = 1'b0, upd_ready_i = 1'b0;
    logic [31:0] correct_pc_i = '0, update_pc_i = '0;
    logic        redirect_valid_o, flush_if_o, flush_id_o, stall_o, upd_valid_o, upd_taken_o, upd_overflow_o;
    logic [31:0] redirect_pc_o, upd_pc_o;
    logic [3:0]  ctl;
    int          checks = 0, failures = 0;

    branch_recovery_ctrl #(.size(32), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .reset(reset), .ex_valid_i(ex_valid_i), .misprediction_i(misprediction_i),
        .correct_pc_i(correct_pc_i), .update_valid_i(update_valid_i), .update_pc_i(update_pc_i),
        .update_taken_i(update_taken_i), .redirect_ready_i(redirect_ready_i), .upd_ready_i(upd_ready_i),
        .redirect_valid_o(redirect_valid_o), .redirect_pc_o(redirect_pc_o), .flush_if_o(flush_if_o),
        .flush_id_o(flush_id_o), .stall_o(stall_o), .upd_valid_o(upd_valid_o), .upd_pc_o(upd_pc_o),
        .upd_taken_o(upd_taken_o), .upd_overflow_o(upd_overflow_o)
    );

    always #5 clk = ~clk;
    assign ctl = {redirect_valid_o, flush_if_o, flush_id_o, stall_o};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL reset_ctl got=%b exp=0000", ctl); end
        checks++; if ({upd_valid_o, upd_overflow_o} !== 2'b00) begin failures++; $display("FAIL reset_fifo got=%b exp=00", {upd_valid_o, upd_overflow_o}); end
        checks++; if (redirect_pc_o !== 32'h0 || upd_pc_o !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h/%h exp=0/0", redirect_pc_o, upd_pc_o); end
        reset = 1'b1;
    endtask

    task automatic test_redirect();
        ex_valid_i = 1; misprediction_i = 1; correct_pc_i = 32'h100; redirect_ready_i = 1;
        step();
        ex_valid_i = 0; misprediction_i = 0;
        checks++; if (ctl !== 4'b1111) begin failures++; $display("FAIL redir_ctl got=%b exp=1111", ctl); end
        checks++; if (redirect_pc_o !== 32'h100) begin failures++; $display("FAIL redir_pc got=%h exp=100", redirect_pc_o); end
        step();
        checks++; if (ctl !== 4'b0110) begin failures++; $display("FAIL drain1_ctl got=%b exp=0110", ctl); end
        step();
        checks++; if (ctl !== 4'b0110) begin failures++; $display("FAIL drain2_ctl got=%b exp=0110", ctl); end
        step();
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL post_drain_ctl got=%b exp=0000", ctl); end
        redirect_ready_i = 0;
    endtask

    task automatic test_hold();
        ex_valid_i = 1; misprediction_i = 1; correct_pc_i = 32'h200;
        step();
        correct_pc_i = 32'h300;
        for (int i = 0; i < 5; i++) begin
            checks++; if (ctl !== 4'b1111 || redirect_pc_o !== 32'h200) begin failures++; $display("FAIL hold_%0d got=%b/%h exp=1111/200", i, ctl, redirect_pc_o); end
            step();
        end
        ex_valid_i = 0; misprediction_i = 0; redirect_ready_i = 1;
        checks++; if (ctl !== 4'b1111) begin failures++; $display("FAIL hold_end_ctl got=%b exp=1111", ctl); end
        step();
        checks++; if (ctl !== 4'b0110) begin failures++; $display("FAIL hold_drain_ctl got=%b exp=0110", ctl); end
        step();
        step();
        checks++; if (ctl !== 4'b0000 || redirect_pc_o !== 32'h200) begin failures++; $display("FAIL hold_idle got=%b/%h exp=0000/200", ctl, redirect_pc_o); end
        redirect_ready_i = 0;
    endtask

    task automatic test_overflow();
        logic [31:0] pcs [3] = '{32'h10, 32'h20, 32'h30};
        logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
        upd_ready_i = 0; ex_valid_i = 1; update_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            update_pc_i = pcs[i]; update_taken_i = tk[i];
            step();
        end
        ex_valid_i = 0; update_valid_i = 0;
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o} !== {1'b1, 32'h10, 1'b1}) begin failures++; $display("FAIL ovf_head got=%b/%h/%b exp=1/10/1", upd_valid_o, upd_pc_o, upd_taken_o); end
        checks++; if (upd_overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", upd_overflow_o); end
        upd_ready_i = 1;
        step();
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o} !== {1'b1, 32'h20, 1'b0}) begin failures++; $display("FAIL ovf_second got=%b/%h/%b exp=1/20/0", upd_valid_o, upd_pc_o, upd_taken_o); end
        step();
        checks++; if ({upd_valid_o, upd_overflow_o} !== 2'b01) begin failures++; $display("FAIL ovf_empty got=%b exp=01", {upd_valid_o, upd_overflow_o}); end
        upd_ready_i = 0;
    endtask

    task automatic test_full_pushpop();
        ex_valid_i = 1; update_valid_i = 1;
        update_pc_i = 32'h40; update_taken_i = 0; step();
        update_pc_i = 32'h50; update_taken_i = 1; step();
        checks++; if ({upd_valid_o, upd_pc_o} !== {1'b1, 32'h40}) begin failures++; $display("FAIL full_head got=%b/%h exp=1/40", upd_valid_o, upd_pc_o); end
        upd_ready_i = 1; update_pc_i = 32'h60; update_taken_i = 1;
        step();
        ex_valid_i = 0; update_valid_i = 0;
        checks++; if (upd_overflow_o !== 1'b0) begin failures++; $display("FAIL pushpop_ovf got=%b exp=0", upd_overflow_o); end
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o} !== {1'b1, 32'h50, 1'b1}) begin failures++; $display("FAIL pushpop_h1 got=%b/%h/%b exp=1/50/1", upd_valid_o, upd_pc_o, upd_taken_o); end
        step();
        checks++; if ({upd_valid_o, upd_pc_o, upd_taken_o} !== {1'b1, 32'h60, 1'b1}) begin failures++; $display("FAIL pushpop_h2 got=%b/%h/%b exp=1/60/1", upd_valid_o, upd_pc_o, upd_taken_o); end
        step();
        checks++; if (upd_valid_o !== 1'b0) begin failures++; $display("FAIL pushpop_empty got=%b exp=0", upd_valid_o); end
        upd_ready_i = 0;
    endtask

    task automatic test_mispredict_update();
        ex_valid_i = 1; misprediction_i = 1; correct_pc_i = 32'h500; redirect_ready_i = 1;
        update_valid_i = 1; update_pc_i = 32'h70; update_taken_i = 1;
        step();
        misprediction_i = 0; update_pc_i = 32'h80;
        checks++; if (ctl !== 4'b1111 || redirect_pc_o !== 32'h500) begin failures++; $display("FAIL mu_redir got=%b/%h exp=1111/500", ctl, redirect_pc_o); end
        checks++; if ({upd_valid_o, upd_pc_o} !== {1'b1, 32'h70}) begin failures++; $display("FAIL mu_push got=%b/%h exp=1/70", upd_valid_o, upd_pc_o); end
        step();
        step();
        step();
        ex_valid_i = 0; update_valid_i = 0; redirect_ready_i = 0;
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL mu_idle got=%b exp=0000", ctl); end
        upd_ready_i = 1;
        checks++; if ({upd_valid_o, upd_pc_o} !== {1'b1, 32'h70}) begin failures++; $display("FAIL mu_head got=%b/%h exp=1/70", upd_valid_o, upd_pc_o); end
        step();
        checks++; if (upd_valid_o !== 1'b0) begin failures++; $display("FAIL mu_drain_discard got=%b exp=0", upd_valid_o); end
        upd_ready_i = 0;
    endtask

    task automatic test_reset_in_drain();
        ex_valid_i = 1; misprediction_i = 1; correct_pc_i = 32'h600; redirect_ready_i = 1;
        update_valid_i = 1; update_pc_i = 32'h90; update_taken_i = 1;
        step();
        ex_valid_i = 0; misprediction_i = 0; update_valid_i = 0;
        step();
        checks++; if (ctl !== 4'b0110 || upd_valid_o !== 1'b1) begin failures++; $display("FAIL rd_pre got=%b/%b exp=0110/1", ctl, upd_valid_o); end
        reset = 0;
        step();
        checks++; if ({ctl, upd_valid_o, upd_taken_o, upd_overflow_o} !== 7'b0) begin failures++; $display("FAIL rd_ctl got=%b exp=0000000", {ctl, upd_valid_o, upd_taken_o, upd_overflow_o}); end
        checks++; if (redirect_pc_o !== 32'h0 || upd_pc_o !== 32'h0) begin failures++; $display("FAIL rd_pc got=%h/%h exp=0/0", redirect_pc_o, upd_pc_o); end
        reset = 1; ex_valid_i = 1; misprediction_i = 1; correct_pc_i = 32'hA0;
        step();
        ex_valid_i = 0; misprediction_i = 0;
        checks++; if (ctl !== 4'b1111 || redirect_pc_o !== 32'hA0) begin failures++; $display("FAIL first_after_reset got=%b/%h exp=1111/a0", ctl, redirect_pc_o); end
        step();
        step();
        step();
        checks++; if (ctl !== 4'b0000) begin failures++; $display("FAIL far_idle got=%b exp=0000", ctl); end
        redirect_ready_i = 0;
    endtask

    initial begin
        test_reset();
        test_redirect();
        test_hold();
        test_overflow();
        test_reset();
        test_full_pushpop();
        test_mispredict_update();
        test_reset_in_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
